// File: rtl/txtlcd_3wire_responder.sv
// Display-side responder for the 3-wire text-LCD serial link: frame decode and command execution on a character RAM.
// Read-back of read frames is compiled in with `define TXTLCD_RESPONDER_READ_EN.
module txtlcd_3wire_responder #(
  parameter int MAIN_CLK    = 50_000_000,
  parameter int LCD_SIZE    = 80,
  parameter int ADDR_BITS   = 7,
  parameter int IDLE_CYCLES = 256
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_scl,
  input  logic                 in_sda,
  output logic                 out_sda,
  input  logic                 in_lcd_reset,
  input  logic [ADDR_BITS-1:0] in_mem_addr,
  output logic [7:0]           out_mem_word,
  output logic [ADDR_BITS-1:0] out_addr,
  output logic                 out_busy,
  output logic [7:0]           out_last_cmd,
  output logic                 out_frame_done,
  output logic                 out_frame_err,
  output logic                 out_overrun
);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam logic [ADDR_BITS-1:0] LAST_A   = ADDR_BITS'(LCD_SIZE - 1);
  localparam logic [ADDR_BITS-1:0] ONE_A    = ADDR_BITS'(1);
  localparam logic [ADDR_BITS:0]   SIZE_X   = (ADDR_BITS + 1)'(LCD_SIZE);
  localparam logic [7:0]           SIZE_8   = 8'(LCD_SIZE);
  localparam logic [IW-1:0]        IDLE_HIT = IW'(IDLE_CYCLES - 1);
  localparam logic [IW-1:0]        IDLE_SAT = IW'(IDLE_CYCLES);

  if (MAIN_CLK <= 0 || (2 ** ADDR_BITS) < LCD_SIZE) begin : g_param_check
    $error("txtlcd_3wire_responder: inconsistent parameters");
  end

  typedef enum logic [2:0] {S_START, S_WR_LO, S_WR_HI, S_EXEC, S_RD, S_SKIP} state_t;

  logic scl_s1_q, scl_s2_q, scl_prev_q, sda_s1_q, sda_s2_q, lrst_s1_q, lrst_s2_q;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
    end else begin
      scl_s1_q   <= in_scl;
      scl_s2_q   <= scl_s1_q;
      scl_prev_q <= scl_s2_q;
      sda_s1_q   <= in_sda;
      sda_s2_q   <= sda_s1_q;
    end
    lrst_s1_q <= in_lcd_reset;
    lrst_s2_q <= lrst_s1_q;
  end

  logic rst_any, rise, fall, byte_done, idle_hit;
  logic [7:0] byte_in;

  state_t state_q, state_d;
  logic [2:0]           bit_q, bit_d;
  logic [6:0]           sh_q, sh_d;
  logic                 rs_q, rs_d;
  logic [3:0]           dlo_q, dlo_d;
  logic [7:0]           data_q, data_d;
  logic [IW-1:0]        idle_q, idle_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d, addr_inc, clr_q, clr_d;
  logic                 busy_q, busy_d, done_q, done_d, err_q, err_d, ovr_q, ovr_d;
  logic                 sda_q, sda_d;
  logic [7:0]           last_q, last_d, mem_word_q;
`ifdef TXTLCD_RESPONDER_READ_EN
  logic [7:0]           rd_sh_q, rd_sh_d;
`endif

  logic [7:0]           ram_q [LCD_SIZE];
  logic                 we;
  logic [ADDR_BITS-1:0] waddr;
  logic [7:0]           wdata;

  assign rst_any   = in_rst | ~lrst_s2_q;
  assign rise      = scl_s2_q & ~scl_prev_q;
  assign fall      = ~scl_s2_q & scl_prev_q;
  assign byte_in   = {sda_s2_q, sh_q};
  assign byte_done = rise && (bit_q == 3'd7);
  assign idle_hit  = scl_s2_q && (idle_q == IDLE_HIT);
  assign addr_inc  = (addr_q == LAST_A) ? '0 : addr_q + ONE_A;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    rs_d    = rs_q;
    dlo_d   = dlo_q;
    data_d  = data_q;
    addr_d  = addr_q;
    clr_d   = clr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    ovr_d   = ovr_q;
    sda_d   = sda_q;
    last_d  = last_q;
`ifdef TXTLCD_RESPONDER_READ_EN
    rd_sh_d = rd_sh_q;
`endif
    we      = 1'b0;
    waddr   = clr_q;
    wdata   = 8'h20;
    idle_d  = scl_s2_q ? ((idle_q == IDLE_SAT) ? idle_q : idle_q + IW'(1)) : '0;

    // Clear loop runs beside the frame FSM so bits arriving mid-clear keep shifting in
    if (busy_q) begin
      we = 1'b1;
      if (clr_q == LAST_A) begin
        busy_d = 1'b0;
        addr_d = '0;
        clr_d  = '0;
      end else begin
        clr_d = clr_q + ONE_A;
      end
    end

    if (rise && state_q != S_EXEC) begin
      sh_d  = byte_in[7:1];
      bit_d = bit_q + 3'd1;
    end

    case (state_q)
      S_START: begin
        if (byte_done) begin
          if (byte_in[4:0] != 5'h1f || byte_in[7]) begin
            err_d   = 1'b1;
            state_d = S_SKIP;
          end else begin
            rs_d = byte_in[6];
            if (byte_in[5]) begin
              state_d = S_RD;
`ifdef TXTLCD_RESPONDER_READ_EN
              if (byte_in[6]) begin
                rd_sh_d = ram_q[addr_q];
                addr_d  = addr_inc;
              end else begin
                rd_sh_d = {busy_q, 7'(addr_q)};
              end
`endif
            end else begin
              state_d = S_WR_LO;
            end
          end
        end
      end
      S_WR_LO: begin
        if (byte_done) begin
          dlo_d   = byte_in[3:0];
          state_d = S_WR_HI;
        end
      end
      S_WR_HI: begin
        if (byte_done) begin
          data_d  = {byte_in[3:0], dlo_q};
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        done_d  = 1'b1;
        state_d = S_START;
        if (rs_q) begin
          if (busy_q) begin
            ovr_d = 1'b1;
          end else begin
            we     = 1'b1;
            waddr  = addr_q;
            wdata  = data_q;
            addr_d = addr_inc;
          end
        end else if (data_q == 8'h01) begin
          // A clear during an ongoing clear restarts it from cell 0
          last_d = data_q;
          busy_d = 1'b1;
          clr_d  = '0;
        end else if (busy_q) begin
          ovr_d = 1'b1;
        end else begin
          last_d = data_q;
          if (data_q[7:1] == 7'h01) begin
            addr_d = '0;
          end else if (data_q[7]) begin
            addr_d = ({1'b0, data_q[6:0]} < SIZE_8) ? ADDR_BITS'(data_q[6:0]) : '0;
          end
        end
      end
      S_RD: begin
`ifdef TXTLCD_RESPONDER_READ_EN
        if (fall) begin
          sda_d   = rd_sh_q[0];
          rd_sh_d = {1'b1, rd_sh_q[7:1]};
        end
`endif
        if (byte_done) begin
          sda_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_START;
        end
      end
      S_SKIP: ;
      default: state_d = S_START;
    endcase

    // Long SCL-high resynchronises any serial state; a half-executed write is never cut short
    if (idle_hit && state_q != S_EXEC) begin
      bit_d   = 3'd0;
      state_d = S_START;
      sda_d   = 1'b1;
    end
  end

  always_ff @(posedge in_clk) begin
    if (rst_any) begin
      state_q    <= S_START;
      bit_q      <= 3'd0;
      idle_q     <= '0;
      addr_q     <= '0;
      clr_q      <= '0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
      sda_q      <= 1'b1;
      last_q     <= 8'h00;
      mem_word_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      idle_q     <= idle_d;
      addr_q     <= addr_d;
      clr_q      <= clr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ovr_q      <= ovr_d;
      sda_q      <= sda_d;
      last_q     <= last_d;
      mem_word_q <= ({1'b0, in_mem_addr} >= SIZE_X) ? 8'h00 : ram_q[in_mem_addr];
    end
  end

  always_ff @(posedge in_clk) begin
    sh_q   <= sh_d;
    rs_q   <= rs_d;
    dlo_q  <= dlo_d;
    data_q <= data_d;
`ifdef TXTLCD_RESPONDER_READ_EN
    rd_sh_q <= rd_sh_d;
`endif
    if (we) ram_q[waddr] <= wdata;
  end

  assign out_sda        = sda_q;
  assign out_mem_word   = mem_word_q;
  assign out_addr       = addr_q;
  assign out_busy       = busy_q;
  assign out_last_cmd   = last_q;
  assign out_frame_done = done_q;
  assign out_frame_err  = err_q;
  assign out_overrun    = ovr_q;
endmodule

// File: tb/tb_txtlcd_3wire_responder.sv
// Bench for txtlcd_3wire_responder: directed protocol cases plus random frames against a frame-level LCD model.
module tb_txtlcd_3wire_responder;
  localparam int N = 80;

  logic clk = 1'b0, rst = 1'b1, scl = 1'b1, sda = 1'b1, lrst = 1'b1;
  logic [6:0] maddr = '0;
  logic       out_sda, out_busy, out_frame_done, out_frame_err, out_overrun;
  logic [7:0] out_mem_word, out_last_cmd;
  logic [6:0] out_addr;

  txtlcd_3wire_responder dut (
    .in_clk(clk), .in_rst(rst), .in_scl(scl), .in_sda(sda), .out_sda(out_sda),
    .in_lcd_reset(lrst), .in_mem_addr(maddr), .out_mem_word(out_mem_word),
    .out_addr(out_addr), .out_busy(out_busy), .out_last_cmd(out_last_cmd),
    .out_frame_done(out_frame_done), .out_frame_err(out_frame_err), .out_overrun(out_overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [7:0] m_ram [N];
  int  m_addr = 0, m_frames = 0, done_cnt = 0, hp = 3;
  logic [7:0] m_last = 8'h00;
  bit  m_err = 0, m_ovr = 0;
  bit  chk_en = 0, fix_ma = 0;
  int  fix_val = 0, ma_last = 0;

  task automatic check(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Per-cycle comparison against the model while the bus is quiet
  always @(negedge clk) begin
    if (chk_en) begin
      check("addr", out_addr, m_addr);
      check("busy", out_busy, 0);
      check("last_cmd", out_last_cmd, m_last);
      check("frame_err", out_frame_err, m_err);
      check("overrun", out_overrun, m_ovr);
      check("sda_idle", out_sda, 1);
      check("mem_word", out_mem_word, (ma_last >= N) ? 0 : int'(m_ram[ma_last]));
    end
    if (out_frame_done) done_cnt++;
    maddr   = fix_ma ? 7'(fix_val) : 7'($urandom_range(0, 127));
    ma_last = maddr;
  end

  task automatic wait_n(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(bit b);
    scl = 1'b0; sda = b; wait_n(hp);
    scl = 1'b1; wait_n(hp);
  endtask

  task automatic send_byte(logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic recv_byte(output logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      scl = 1'b0; wait_n(hp);
      v[i] = out_sda;
      scl = 1'b1; wait_n(hp);
    end
  endtask

  task automatic send_frame(bit rs, logic [7:0] d);
    send_byte({1'b0, rs, 1'b0, 5'h1f});
    send_byte({4'($urandom), d[3:0]});
    send_byte({4'($urandom), d[7:4]});
  endtask

  task automatic open_chk();
    chk_en = 1'b1;
    wait_n($urandom_range(3, 8));
    check("frames", done_cnt, m_frames);
    chk_en = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_ram[i] = 8'h20;
    m_addr = 0;
  endtask

  task automatic peek(int a, int exp, string nm);
    fix_ma = 1'b1; fix_val = a;
    wait_n(3);
    check(nm, out_mem_word, exp);
    fix_ma = 1'b0;
  endtask

  task automatic do_write(bit rs, logic [7:0] d);
    chk_en = 1'b0;
    send_frame(rs, d);
    m_frames++;
    if (rs) begin
      m_ram[m_addr] = d;
      m_addr = (m_addr + 1) % N;
    end else begin
      m_last = d;
      if (d == 8'h01) model_clear();
      else if (d == 8'h02 || d == 8'h03) m_addr = 0;
      else if (d[7]) m_addr = (int'(d[6:0]) < N) ? int'(d[6:0]) : 0;
    end
    wait_n((!rs && d == 8'h01) ? 100 : 6);
    open_chk();
  endtask

  task automatic do_read(bit rs, output logic [7:0] got);
    logic [7:0] exp;
    chk_en = 1'b0;
    exp = rs ? m_ram[m_addr] : {1'b0, 7'(m_addr)};
    send_byte({1'b0, rs, 1'b1, 5'h1f});
    recv_byte(got);
`ifdef TXTLCD_RESPONDER_READ_EN
    check("rd_word", got, exp);
    if (rs) m_addr = (m_addr + 1) % N;
`else
    check("rd_sda_held", got, 8'hff);
`endif
    m_frames++;
    wait_n(6);
    open_chk();
  endtask

  task automatic do_bad(logic [7:0] v);
    chk_en = 1'b0;
    send_byte(v);
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    m_err = 1'b1;
    wait_n(270);
    open_chk();
  endtask

  initial begin
    logic [7:0] got, v;
    int n;
    wait_n(5);
    check("rst_busy", out_busy, 1);
    check("rst_addr", out_addr, 0);
    check("rst_last", out_last_cmd, 0);
    check("rst_err", out_frame_err, 0);
    check("rst_ovr", out_overrun, 0);
    check("rst_sda", out_sda, 1);
    check("rst_done", out_frame_done, 0);
    check("rst_mem", out_mem_word, 0);
    rst = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (out_busy && n < 200);
    check("busy_cycles", n, 80);
    @(negedge clk);
    model_clear();
    open_chk();
    peek(0, 8'h20, "clr_ram0");
    peek(79, 8'h20, "clr_ram79");

    // First data write, with exact latency from the last SCL rise
    send_byte(8'h5F); send_byte(8'h01);
    for (int i = 0; i < 7; i++) send_bit(i == 2);
    scl = 1'b0; sda = 1'b0; wait_n(hp); scl = 1'b1;
    wait_n(3);
    check("lat_addr_early", out_addr, 0);
    wait_n(1);
    check("lat_addr", out_addr, 1);
    check("lat_done", out_frame_done, 1);
    wait_n(1);
    check("done_one_cycle", out_frame_done, 0);
    wait_n(4);
    m_ram[0] = 8'h41; m_addr = 1; m_frames++;
    open_chk();
    peek(0, 8'h41, "ram0_41");

    do_write(0, 8'hCF);
    do_write(1, 8'h42);
    peek(79, 8'h42, "ram79_42");
    check("wrap_addr", out_addr, 0);
    do_write(0, 8'hD5);
    check("addr85_zero", out_addr, 0);
    check("last_d5", out_last_cmd, 8'hD5);
    peek(100, 8'h00, "mem_out_of_range");

    // Partial frame abandoned by the idle timeout
    chk_en = 1'b0;
    send_byte(8'h5F);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    wait_n(270);
    open_chk();
    check("partial_no_err", out_frame_err, 0);
    do_write(1, 8'h44);
    peek(0, 8'h44, "resync_write");

    do_bad(8'h9F);
    do_write(0, 8'h02);
    do_write(1, 8'h43);
    peek(0, 8'h43, "ram0_43");
    check("err_sticky", out_frame_err, 1);

    // Clear command followed immediately by a data frame inside the clear loop
    chk_en = 1'b0;
    hp = 1;
    send_frame(0, 8'h01);
    send_frame(1, 8'h57);
    hp = 3;
    wait_n(4);
    check("busy_mid_clear", out_busy, 1);
    wait_n(96);
    model_clear(); m_last = 8'h01; m_ovr = 1'b1; m_frames += 2;
    open_chk();
    check("overrun_set", out_overrun, 1);
    peek(0, 8'h20, "dropped_write");

    do_write(0, 8'h85);
    do_write(1, 8'h48);
    do_write(0, 8'h85);
    do_read(1, got);
`ifdef TXTLCD_RESPONDER_READ_EN
    check("rd_data_lit", got, 8'h48);
    check("rd_addr_inc", out_addr, 6);
`else
    check("rd_addr_kept", out_addr, 5);
`endif
    do_read(0, got);
`ifdef TXTLCD_RESPONDER_READ_EN
    check("rd_status_lit", got, 8'h06);
`endif

    // LCD reset pulled low mid-frame
    chk_en = 1'b0;
    send_byte(8'h5F);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    lrst = 1'b0; wait_n(5); lrst = 1'b1;
    wait_n(100);
    model_clear(); m_last = 8'h00; m_err = 1'b0; m_ovr = 1'b0;
    open_chk();
    check("lrst_ovr", out_overrun, 0);

    for (int k = 0; k < 60; k++) begin
      int r;
      r  = $urandom_range(0, 19);
      hp = $urandom_range(3, 5);
      if (r <= 7) do_write(1, 8'($urandom));
      else if (r <= 9) do_write(0, 8'h80 | 8'($urandom_range(0, 127)));
      else if (r == 10) do_write(0, 8'($urandom_range(2, 3)));
      else if (r <= 12) do_write(0, 8'($urandom_range(4, 127)));
      else if (r <= 16) do_read(1'($urandom), got);
      else if (r == 17) do_write(0, 8'h01);
      else begin
        do v = 8'($urandom); while (v[4:0] == 5'h1f && !v[7]);
        do_bad(v);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
